seq_pattern_tx: RTL

Serial frame transmitter that drives a 1-bit stream for the Moore overlapping sequence detector. Each frame is a fixed 5-bit preamble `10110` followed by a parallel payload word, shifted out MSB-first. Frames are separated by a fixed run of idle zeros. The block accepts payload words through a valid/ready handshake and sits upstream of the detector's `din` input, so it doubles as the detector's stimulus source in loopback tests.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_piso.sv | 36 +++
 rtl/seq_pattern_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the Moore
// overlapping sequence detector it feeds.
package seq_pkg;

    localparam int unsigned SEQ_PAT_LEN = 5;
    localparam logic [SEQ_PAT_LEN-1:0] SEQ_PATTERN = 5'b10110;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        GAP
    } tx_state_t;

    // Detector states name the longest received suffix that is a prefix of 10110
    typedef enum logic [2:0] {
        DET_S0,
        DET_S1,
        DET_S10,
        DET_S101,
        DET_S1011,
        DET_S10110
    } det_state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register; exposes the MSB it will hold after
// the coming edge so the owner can register the serial bit alongside it.
module seq_piso #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              next_msb_c
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    assign next_msb_c = sr_d[DATA_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle gap.
// Outputs are registered from the next-state values, so they track the state register exactly.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned          DATA_W  = 8,
    parameter int unsigned          PAT_LEN = SEQ_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = SEQ_PATTERN,
    parameter int unsigned          GAP     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(max2(max2(PAT_LEN, DATA_W), max2(GAP, 2)));

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, shift_en, next_msb_c;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             tx_ready_q, tx_ready_d;

    seq_piso #(.DATA_W(DATA_W)) u_piso (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .shift_i    (shift_en),
        .data_i     (tx_data),
        .next_msb_c (next_msb_c)
    );

    // Next-state, counter and shift control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(PAT_LEN - 1);
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = PAYLOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PAYLOAD: begin
                shift_en = 1'b1;
                if (cnt_q == '0) begin
                    if (GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_W'(GAP - 1);
                        state_d = seq_pkg::GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            seq_pkg::GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the values the registers will hold next cycle
    always_comb begin
        dout_d        = 1'b0;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        tx_ready_d    = (state_d == IDLE);
        case (state_d)
            PREAMBLE: begin
                dout_d        = PATTERN[cnt_d];
                dout_valid_d  = 1'b1;
                frame_start_d = (state_q == IDLE);
            end
            PAYLOAD: begin
                dout_d       = next_msb_c;
                dout_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dout_q        <= 1'b0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            tx_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            tx_ready_q    <= tx_ready_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = !tx_ready_q;

endmodule
